mem_stage_stack_ctrl: RTL and testbench

Memory-stage datapath and sequencer that sits directly upstream of the MEM/WB pipeline register. It owns the 256x8 data memory and the stack pointer. It executes LDD/STD, PUSH/POP and CALL-push accesses from the M stage, and produces read_data_M for MEM/WB. It also runs the multi-cycle interrupt-entry and RTI sequences, stalling the front of the pipe while it does so.

---
 rtl/mem_stage_stack_ctrl_if.sv | 37 +++
 rtl/mem_stage_stack_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_stage_stack_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_stack_ctrl_if.sv
// M-stage bus of the memory-stage stack controller: pipeline requests, interrupt
// inputs, and the read data / stall / PC and CCR restore outputs.
interface mem_stage_stack_ctrl_if;
  logic       mem_rd_en_M;
  logic       mem_wr_en_M;
  logic [1:0] addr_sel_M;
  logic [7:0] alu_out_M;
  logic [7:0] wdata_M;
  logic       rti_M;
  logic       intr_i;
  logic [7:0] pc_int_i;
  logic [3:0] flags_i;
  logic [7:0] read_data_M;
  logic [7:0] sp_o;
  logic       stall_o;
  logic       pc_load_o;
  logic [7:0] pc_val_o;
  logic       flags_load_o;
  logic [3:0] flags_val_o;
  logic       stack_err_o;
  logic [2:0] state_o;

  // Pipeline side drives requests and consumes results.
  modport master (
    output mem_rd_en_M, mem_wr_en_M, addr_sel_M, alu_out_M, wdata_M, rti_M,
           intr_i, pc_int_i, flags_i,
    input  read_data_M, sp_o, stall_o, pc_load_o, pc_val_o, flags_load_o,
           flags_val_o, stack_err_o, state_o
  );

  modport slave (
    input  mem_rd_en_M, mem_wr_en_M, addr_sel_M, alu_out_M, wdata_M, rti_M,
           intr_i, pc_int_i, flags_i,
    output read_data_M, sp_o, stall_o, pc_load_o, pc_val_o, flags_load_o,
           flags_val_o, stack_err_o, state_o
  );
endinterface

// File: rtl/mem_stage_stack_ctrl.sv
// Memory stage: 256x8 data memory, stack pointer, and the interrupt-entry / RTI
// sequencer that stalls the front of the pipe while it pushes or pops a frame.
module mem_stage_stack_ctrl #(
  parameter logic [7:0] SP_RESET     = 8'hFF,
  parameter logic [7:0] INT_VEC_ADDR = 8'h00
) (
  input logic                    clk,
  input logic                    reset,
  mem_stage_stack_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INT_PC  = 3'd1,
    S_INT_FL  = 3'd2,
    S_INT_VEC = 3'd3,
    S_RTI_FL  = 3'd4,
    S_RTI_PC  = 3'd5
  } state_e;

  state_e     state_q;
  logic [7:0] sp_q, sp_d, sp_inc, sp_dec;
  logic       int_pending_q;
  logic       stack_err_q;
  logic       stall_q;
  logic       pc_load_q;
  logic       flags_load_q;

  logic [7:0] mem_q [256];

  logic       is_idle, op_valid, op_wr, op_rd, op_push, op_pop;
  logic [7:0] op_addr;
  logic       int_req, enter_int;
  logic       mem_we;
  logic [7:0] mem_waddr, mem_wdata;
  logic       sp_down, sp_up, err_set;
  logic [7:0] top_word;

  // Pipeline request decode; only honoured while the sequencer is idle.
  always_comb begin
    sp_inc    = sp_q + 8'd1;
    sp_dec    = sp_q - 8'd1;
    is_idle   = (state_q == S_IDLE);
    op_valid  = is_idle && (bus.addr_sel_M != 2'b11);
    op_wr     = op_valid && bus.mem_wr_en_M;
    op_rd     = op_valid && bus.mem_rd_en_M && !bus.mem_wr_en_M;
    case (bus.addr_sel_M)
      2'b00:   op_addr = bus.alu_out_M;
      2'b01:   op_addr = sp_q;
      default: op_addr = sp_inc;
    endcase
    op_push   = op_wr && (bus.addr_sel_M == 2'b01);
    op_pop    = op_rd && (bus.addr_sel_M == 2'b10);
    int_req   = bus.intr_i || int_pending_q;
    enter_int = is_idle && int_req;
  end

  // Single write port shared by pipeline stores and the interrupt frame push.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = op_addr;
    mem_wdata = bus.wdata_M;
    case (state_q)
      S_IDLE: mem_we = op_wr;
      S_INT_PC: begin
        mem_we    = 1'b1;
        mem_waddr = sp_q;
        mem_wdata = bus.pc_int_i;
      end
      S_INT_FL: begin
        mem_we    = 1'b1;
        mem_waddr = sp_q;
        mem_wdata = {4'b0000, bus.flags_i};
      end
      default: mem_we = 1'b0;
    endcase
    if (reset) mem_we = 1'b0;
  end

  always_comb begin
    sp_down = op_push || (state_q == S_INT_PC) || (state_q == S_INT_FL);
    sp_up   = op_pop  || (state_q == S_RTI_FL) || (state_q == S_RTI_PC);
    if (sp_down)    sp_d = sp_dec;
    else if (sp_up) sp_d = sp_inc;
    else            sp_d = sp_q;
    err_set = (sp_down && (sp_q == 8'h00)) || (sp_up && (sp_q == 8'hFF));
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Sequencer: strobes are registered on the transition into the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sp_q          <= SP_RESET;
      int_pending_q <= 1'b0;
      stack_err_q   <= 1'b0;
      stall_q       <= 1'b0;
      pc_load_q     <= 1'b0;
      flags_load_q  <= 1'b0;
    end else begin
      sp_q          <= sp_d;
      if (err_set) stack_err_q <= 1'b1;
      int_pending_q <= enter_int ? 1'b0 : (int_pending_q | bus.intr_i);
      pc_load_q     <= 1'b0;
      flags_load_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (int_req) begin
            state_q <= S_INT_PC;
            stall_q <= 1'b1;
          end else if (bus.rti_M) begin
            state_q      <= S_RTI_FL;
            stall_q      <= 1'b1;
            flags_load_q <= 1'b1;
          end
        end
        S_INT_PC: state_q <= S_INT_FL;
        S_INT_FL: begin
          state_q   <= S_INT_VEC;
          pc_load_q <= 1'b1;
        end
        S_RTI_FL: begin
          state_q   <= S_RTI_PC;
          pc_load_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign top_word = mem_q[sp_inc];

  // Reads are forced to zero outside an idle, read-only access so MEM/WB sees no stale data.
  assign bus.read_data_M  = op_rd ? mem_q[op_addr] : 8'h00;
  assign bus.sp_o         = sp_q;
  assign bus.stall_o      = stall_q;
  assign bus.pc_load_o    = pc_load_q;
  assign bus.pc_val_o     = !pc_load_q ? 8'h00 :
                            (state_q == S_INT_VEC) ? mem_q[INT_VEC_ADDR] : top_word;
  assign bus.flags_load_o = flags_load_q;
  assign bus.flags_val_o  = flags_load_q ? top_word[3:0] : 4'h0;
  assign bus.stack_err_o  = stack_err_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_mem_stage_stack_ctrl.sv
// Bench for mem_stage_stack_ctrl: stack push/pop, loads/stores, interrupt entry,
// RTI, pending interrupts and reset abort, checked against a small memory/SP model.
module tb_mem_stage_stack_ctrl;

  logic clk;
  logic reset;

  mem_stage_stack_ctrl_if bus ();

  mem_stage_stack_ctrl #(
    .SP_RESET     (8'hFF),
    .INT_VEC_ADDR (8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  logic [7:0] rd_exp_q [$];
  logic [7:0] pc_exp_q [$];
  logic [3:0] fl_exp_q [$];
  logic       rd_chk = 1'b0;

  logic [7:0] exp_mem [256];
  logic [7:0] m_sp;
  logic       m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: pops expected values when the DUT produces read data or strobes.
  always @(negedge clk) begin
    if (rd_chk) begin
      if (rd_exp_q.size() == 0) check("rdata_unexpected", 32'd1, 32'd0);
      else check("rdata", {24'd0, bus.read_data_M}, {24'd0, rd_exp_q.pop_front()});
    end
    if (bus.pc_load_o === 1'b1) begin
      if (pc_exp_q.size() == 0) check("pc_load_spurious", 32'd1, 32'd0);
      else check("pc_val", {24'd0, bus.pc_val_o}, {24'd0, pc_exp_q.pop_front()});
    end
    if (bus.flags_load_o === 1'b1) begin
      if (fl_exp_q.size() == 0) check("flags_load_spurious", 32'd1, 32'd0);
      else check("flags_val", {28'd0, bus.flags_val_o}, {28'd0, fl_exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic idle_inputs();
    bus.mem_rd_en_M = 1'b0;
    bus.mem_wr_en_M = 1'b0;
    bus.addr_sel_M  = 2'b11;
    bus.alu_out_M   = 8'h00;
    bus.wdata_M     = 8'h00;
    bus.rti_M       = 1'b0;
    bus.intr_i      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    m_sp  = 8'hFF;
    m_err = 1'b0;
  endtask

  task automatic idle_op(input logic rd, input logic wr, input logic [1:0] sel,
                         input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] a;
    bus.mem_rd_en_M = rd;
    bus.mem_wr_en_M = wr;
    bus.addr_sel_M  = sel;
    bus.alu_out_M   = addr;
    bus.wdata_M     = data;
    a = (sel == 2'b00) ? addr : (sel == 2'b01) ? m_sp : m_sp + 8'd1;
    if (sel != 2'b11 && wr) begin
      exp_mem[a] = data;
      if (sel == 2'b01) begin
        if (m_sp == 8'h00) m_err = 1'b1;
        m_sp = m_sp - 8'd1;
      end
      if (rd) begin
        rd_exp_q.push_back(8'h00);
        rd_chk = 1'b1;
      end
    end else if (sel != 2'b11 && rd) begin
      rd_exp_q.push_back(exp_mem[a]);
      rd_chk = 1'b1;
      if (sel == 2'b10) begin
        if (m_sp == 8'hFF) m_err = 1'b1;
        m_sp = m_sp + 8'd1;
      end
    end
    @(posedge clk); #1;
    rd_chk = 1'b0;
    idle_inputs();
  endtask

  task automatic pulse(input logic intr, input logic rti, input logic [7:0] pc, input logic [3:0] fl);
    bus.intr_i   = intr;
    bus.rti_M    = rti;
    bus.pc_int_i = pc;
    bus.flags_i  = fl;
    @(posedge clk); #1;
    bus.intr_i = 1'b0;
    bus.rti_M  = 1'b0;
  endtask

  // Watches n cycles after a trigger; bit i of each mask is that output in cycle i.
  task automatic run_seq(input int n, input int intr_cyc, input int rst_cyc,
                         output logic [15:0] st_m, output logic [15:0] pc_m,
                         output logic [15:0] fl_m);
    st_m = '0; pc_m = '0; fl_m = '0;
    for (int i = 1; i <= n; i++) begin
      bus.intr_i = (i == intr_cyc);
      reset      = (i == rst_cyc);
      @(negedge clk);
      st_m[i] = bus.stall_o;
      pc_m[i] = bus.pc_load_o;
      fl_m[i] = bus.flags_load_o;
      @(posedge clk); #1;
    end
    bus.intr_i = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic check_regs(input string tag, input logic [7:0] sp, input logic err);
    check({tag, "_sp"},  {24'd0, bus.sp_o}, {24'd0, sp});
    check({tag, "_err"}, {31'd0, bus.stack_err_o}, {31'd0, err});
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] st_m, pc_m, fl_m;

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus.pc_int_i = 8'h00;
    bus.flags_i  = 4'h0;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    check("rst_sp",     {24'd0, bus.sp_o},        32'h0000_00FF);
    check("rst_stall",  {31'd0, bus.stall_o},     32'd0);
    check("rst_pcld",   {31'd0, bus.pc_load_o},   32'd0);
    check("rst_flld",   {31'd0, bus.flags_load_o}, 32'd0);
    check("rst_err",    {31'd0, bus.stack_err_o}, 32'd0);
    check("rst_rdata",  {24'd0, bus.read_data_M}, 32'd0);
    check("rst_state",  {29'd0, bus.state_o},     32'd0);

    // Push A5, 3C then pop twice
    idle_op(1'b0, 1'b1, 2'b01, 8'h00, 8'hA5);
    idle_op(1'b0, 1'b1, 2'b01, 8'h00, 8'h3C);
    check_regs("push2", m_sp, m_err);
    check("push2_sp_abs", {24'd0, bus.sp_o}, 32'h0000_00FD);
    idle_op(1'b1, 1'b0, 2'b10, 8'h00, 8'h00);
    idle_op(1'b1, 1'b0, 2'b10, 8'h00, 8'h00);
    check_regs("pop2", 8'hFF, 1'b0);

    // Vector, then underflowing pop from FF
    idle_op(1'b0, 1'b1, 2'b00, 8'h00, 8'h20);
    idle_op(1'b1, 1'b0, 2'b10, 8'h00, 8'h00);
    check_regs("underflow", 8'h00, 1'b1);

    // STD/LDD, simultaneous rd+wr; error flag sticks
    idle_op(1'b0, 1'b1, 2'b00, 8'h40, 8'h77);
    idle_op(1'b1, 1'b0, 2'b00, 8'h40, 8'h00);
    idle_op(1'b1, 1'b1, 2'b00, 8'h41, 8'h55);
    idle_op(1'b1, 1'b0, 2'b00, 8'h41, 8'h00);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] ra;
      ra = 8'h80 + 8'($urandom_range(0, 15));
      idle_op(1'b0, 1'b1, 2'b00, ra, 8'($urandom_range(0, 255)));
      idle_op(1'b1, 1'b0, 2'b00, ra, 8'h00);
    end
    check_regs("sticky", 8'h00, 1'b1);
    do_reset();
    check_regs("err_clr", 8'hFF, 1'b0);

    // Interrupt entry
    pc_exp_q.push_back(8'h20);
    pulse(1'b1, 1'b0, 8'h12, 4'b1010);
    run_seq(5, 0, 0, st_m, pc_m, fl_m);
    check("int_stall_mask", {16'd0, st_m}, 32'h0000_000E);
    check("int_pcld_mask",  {16'd0, pc_m}, 32'h0000_0008);
    check("int_flld_mask",  {16'd0, fl_m}, 32'h0000_0000);
    m_sp = 8'hFD; exp_mem[8'hFF] = 8'h12; exp_mem[8'hFE] = 8'h0A;
    check_regs("int", m_sp, 1'b0);
    idle_op(1'b1, 1'b0, 2'b00, 8'hFF, 8'h00);
    idle_op(1'b1, 1'b0, 2'b00, 8'hFE, 8'h00);

    // RTI
    fl_exp_q.push_back(4'b1010);
    pc_exp_q.push_back(8'h12);
    pulse(1'b0, 1'b1, 8'h00, 4'h0);
    run_seq(4, 0, 0, st_m, pc_m, fl_m);
    check("rti_stall_mask", {16'd0, st_m}, 32'h0000_0006);
    check("rti_pcld_mask",  {16'd0, pc_m}, 32'h0000_0004);
    check("rti_flld_mask",  {16'd0, fl_m}, 32'h0000_0002);
    m_sp = 8'hFF;
    check_regs("rti", m_sp, 1'b0);

    // Interrupt arriving in RTI_FL is serviced right after RTI_PC
    pc_exp_q.push_back(8'h20);
    pulse(1'b1, 1'b0, 8'h34, 4'h5);
    run_seq(5, 0, 0, st_m, pc_m, fl_m);
    check("int2_pcld_mask", {16'd0, pc_m}, 32'h0000_0008);
    fl_exp_q.push_back(4'h5);
    pc_exp_q.push_back(8'h34);
    pc_exp_q.push_back(8'h20);
    bus.pc_int_i = 8'h56;
    bus.flags_i  = 4'h3;
    pulse(1'b0, 1'b1, 8'h56, 4'h3);
    run_seq(8, 1, 0, st_m, pc_m, fl_m);
    check("pend_stall_mask", {16'd0, st_m}, 32'h0000_0076);
    check("pend_pcld_mask",  {16'd0, pc_m}, 32'h0000_0044);
    check("pend_flld_mask",  {16'd0, fl_m}, 32'h0000_0002);
    m_sp = 8'hFD; exp_mem[8'hFF] = 8'h56; exp_mem[8'hFE] = 8'h03;
    check_regs("pend", m_sp, 1'b0);
    idle_op(1'b1, 1'b0, 2'b00, 8'hFF, 8'h00);
    idle_op(1'b1, 1'b0, 2'b00, 8'hFE, 8'h00);

    // Reset during INT_FL aborts the sequence
    do_reset();
    pulse(1'b1, 1'b0, 8'h99, 4'hF);
    run_seq(5, 0, 2, st_m, pc_m, fl_m);
    check("abort_stall_mask", {16'd0, st_m}, 32'h0000_0006);
    check("abort_pcld_mask",  {16'd0, pc_m}, 32'h0000_0000);
    check("abort_state",      {29'd0, bus.state_o}, 32'd0);
    m_sp = 8'hFF; exp_mem[8'hFF] = 8'h99;
    check_regs("abort", m_sp, 1'b0);
    idle_op(1'b1, 1'b0, 2'b00, 8'hFE, 8'h00);
    idle_op(1'b1, 1'b0, 2'b00, 8'hFF, 8'h00);

    @(posedge clk); #1;
    check("rd_q_drained", rd_exp_q.size(), 32'd0);
    check("pc_q_drained", pc_exp_q.size(), 32'd0);
    check("fl_q_drained", fl_exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
